// File: rtl/wm_pkg.sv
// wm_pkg: shared phase/state types and phase duration table for the washer phase timer
package wm_pkg;
  typedef enum logic [2:0] {NONE, FILL, WASH, RINSE, SPIN, DRAIN, DRY} phase_e;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, DONE, WAIT_DROP} state_e;
  localparam logic [4:0] HOT_FILL_EXTRA = 5'd2;
  // rows: phase index, columns: cycle_duration short/medium/long
  localparam logic [4:0] DUR_TBL [7][3] = '{
    '{5'd0,  5'd0,  5'd0},
    '{5'd4,  5'd4,  5'd4},
    '{5'd10, 5'd16, 5'd22},
    '{5'd6,  5'd8,  5'd10},
    '{5'd4,  5'd6,  5'd8},
    '{5'd3,  5'd3,  5'd3},
    '{5'd10, 5'd14, 5'd20}
  };
  function automatic logic [4:0] phase_dur(phase_e p, logic [1:0] cd, logic [1:0] cloth, logic [1:0] temp);
    logic [1:0] c;
    logic [4:0] d;
    c = (cd == 2'b11) ? 2'b00 : cd;
    d = DUR_TBL[p][c];
    d = (p == FILL && temp == 2'b10) ? d + HOT_FILL_EXTRA : d;
    return ((p == SPIN || p == DRY) && cloth != 2'b00) ? d >> 1 : d;
  endfunction
endpackage

// File: rtl/wm_phase_timer_if.sv
// wm_phase_timer_if: controller <-> phase timer signals
// master (controller side): drives phase enables, pause and configuration; receives done pulses and status
// slave (timer side): the reverse
interface wm_phase_timer_if #(parameter int CNT_W = 8);
  logic fill_water, wash, rinse, spin, drain, dry, pause;
  logic [1:0] cycle_duration, cloth_type, temp_select;
  logic fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done;
  logic [CNT_W-1:0] remaining;
  logic phase_active, enable_error;
  modport master (
    output fill_water, wash, rinse, spin, drain, dry, pause, cycle_duration, cloth_type, temp_select,
    input fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done, remaining, phase_active, enable_error
  );
  modport slave (
    input fill_water, wash, rinse, spin, drain, dry, pause, cycle_duration, cloth_type, temp_select,
    output fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done, remaining, phase_active, enable_error
  );
endinterface

// File: rtl/wm_tick_prescaler.sv
// wm_tick_prescaler: divides clk into time ticks, with clear and freeze control
// ports: clk, reset (sync, active-high), clear (restart at 0), hold (freeze count), tick (1-cycle pulse at wrap)
module wm_tick_prescaler #(parameter int TICK_DIV = 1000) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = !clear && !hold && cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (!hold) cnt <= tick ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/wm_phase_timer.sv
// wm_phase_timer: times each washer phase enable and pulses the matching *_done on expiry
// ports: clk, reset (sync, active-high), bus (slave side: phase enables, pause, configuration in;
//        *_done pulses, remaining ticks, phase_active, enable_error out)
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  wm_phase_timer_if.slave bus
);
  state_e state, state_n;
  phase_e ph, ph_n, new_ph;
  logic [CNT_W-1:0] rem, rem_n;
  logic [5:0] en;
  logic [7:0] enx;
  logic one_hot, multi, stored_en, clear, hold, tick;
  assign en = {bus.dry, bus.drain, bus.spin, bus.rinse, bus.wash, bus.fill_water};
  // padded so NONE (and the unused code) read as a low enable
  assign enx = {1'b0, en, 1'b0};
  assign stored_en = enx[ph];
  assign multi = (en & (en - 6'd1)) != 6'd0;
  assign one_hot = en != 6'd0 && !multi;
  always_comb begin
    new_ph = NONE;
    for (int i = 0; i < 6; i++) if (en[i]) new_ph = phase_e'(3'(i + 1));
  end
  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk(clk), .reset(reset), .clear(clear), .hold(hold), .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ph <= NONE;
      rem <= '0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      rem <= rem_n;
    end
  end
  always_comb begin
    state_n = state;
    ph_n = ph;
    rem_n = rem;
    clear = 1'b1;
    hold = 1'b0;
    case (state)
      IDLE: if (one_hot && !bus.pause) begin
        state_n = LOAD;
        ph_n = new_ph;
      end
      LOAD: begin
        rem_n = CNT_W'(phase_dur(ph, bus.cycle_duration, bus.cloth_type, bus.temp_select));
        state_n = bus.pause ? HOLD : RUN;
      end
      RUN: begin
        clear = 1'b0;
        hold = bus.pause;
        if (bus.pause) state_n = HOLD;
        else if (en == 6'd0) begin
          state_n = IDLE;
          rem_n = '0;
        end else if (one_hot && !stored_en) begin
          state_n = LOAD;
          ph_n = new_ph;
        end else if (tick) begin
          rem_n = rem - CNT_W'(1);
          state_n = rem == CNT_W'(1) ? DONE : RUN;
        end
      end
      HOLD: begin
        clear = 1'b0;
        hold = 1'b1;
        if (!bus.pause && stored_en) state_n = RUN;
        else if (!bus.pause && one_hot) begin
          state_n = LOAD;
          ph_n = new_ph;
        end
      end
      DONE: state_n = WAIT_DROP;
      WAIT_DROP: state_n = stored_en ? WAIT_DROP : IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.fill_done = state == DONE && ph == FILL;
  assign bus.wash_done = state == DONE && ph == WASH;
  assign bus.rinse_done = state == DONE && ph == RINSE;
  assign bus.spin_done = state == DONE && ph == SPIN;
  assign bus.drain_done = state == DONE && ph == DRAIN;
  assign bus.dry_done = state == DONE && ph == DRY;
  assign bus.remaining = rem;
  assign bus.phase_active = state == LOAD || state == RUN || state == HOLD;
  assign bus.enable_error = multi;
endmodule

// File: tb/tb_wm_phase_timer.sv
// tb_wm_phase_timer: randomized self-checking bench for wm_phase_timer against a duration/latency model
module tb_wm_phase_timer;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cycle = 0;
  int errors = 0;
  int checks = 0;
  wm_phase_timer_if #(.CNT_W(8)) bus();
  wm_phase_timer #(.TICK_DIV(TD), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic set_en(input logic [5:0] v);
    {bus.dry, bus.drain, bus.spin, bus.rinse, bus.wash, bus.fill_water} = v;
  endtask

  task automatic set_cfg(input int cd, input int cl, input int tp);
    bus.cycle_duration = 2'(cd);
    bus.cloth_type = 2'(cl);
    bus.temp_select = 2'(tp);
  endtask

  function automatic logic [5:0] done_vec();
    return {bus.dry_done, bus.drain_done, bus.spin_done, bus.rinse_done, bus.wash_done, bus.fill_done};
  endfunction

  // phase p: 0 fill, 1 wash, 2 rinse, 3 spin, 4 drain, 5 dry
  function automatic int ref_dur(input int p, input int cd, input int cl, input int tp);
    int c, d;
    c = (cd == 3) ? 0 : cd;
    case (p)
      0: d = 4 + ((tp == 2) ? 2 : 0);
      1: d = 10 + 6 * c;
      2: d = 6 + 2 * c;
      3: d = 4 + 2 * c;
      4: d = 3;
      default: d = (c == 0) ? 10 : (c == 1) ? 14 : 20;
    endcase
    if ((p == 3 || p == 5) && cl != 0) d = d / 2;
    return d;
  endfunction

  task automatic watch(input int n, output int first, output int cnt, output logic [5:0] seen);
    first = -1;
    cnt = 0;
    seen = '0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (done_vec() != 6'd0) begin
        if (first < 0) first = cycle;
        cnt++;
        seen |= done_vec();
      end
    end
  endtask

  task automatic test_reset();
    set_en('0);
    bus.pause = 1'b0;
    set_cfg(0, 0, 0);
    reset = 1'b1;
    repeat (3) cyc();
    checks++; if (done_vec() !== 6'd0) begin errors++; $display("FAIL reset_done: got %b expected 000000", done_vec()); end
    checks++; if (bus.remaining !== 8'd0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", bus.remaining); end
    checks++; if (bus.phase_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", bus.phase_active); end
    checks++; if (bus.enable_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.enable_error); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_hot_fill();
    int t0, first, cnt;
    logic [5:0] seen;
    set_cfg(0, 0, 2);
    t0 = cycle;
    set_en(6'b000001);
    cyc(); cyc();
    checks++; if (bus.remaining !== 8'd6) begin errors++; $display("FAIL hot_fill_load: got %0d expected 6", bus.remaining); end
    watch(40, first, cnt, seen);
    checks++; if (first != t0 + 26) begin errors++; $display("FAIL hot_fill_time: got %0d expected %0d", first, t0 + 26); end
    checks++; if (cnt != 1 || seen !== 6'b000001) begin errors++; $display("FAIL hot_fill_pulse: got cnt=%0d seen=%b expected cnt=1 seen=000001", cnt, seen); end
    set_en('0);
    cyc(); cyc();
  endtask

  task automatic test_delicate_spin();
    int t0, first, cnt;
    logic [5:0] seen;
    set_cfg(2, 1, 0);
    t0 = cycle;
    set_en(6'b001000);
    cyc(); cyc();
    checks++; if (bus.remaining !== 8'd4) begin errors++; $display("FAIL spin_load: got %0d expected 4", bus.remaining); end
    watch(30, first, cnt, seen);
    checks++; if (first != t0 + 18) begin errors++; $display("FAIL spin_time: got %0d expected %0d", first, t0 + 18); end
    checks++; if (cnt != 1 || seen !== 6'b001000) begin errors++; $display("FAIL spin_pulse: got cnt=%0d seen=%b expected cnt=1 seen=001000", cnt, seen); end
    set_en('0);
    cyc(); cyc();
  endtask

  task automatic test_pause();
    int t0, tp, bad, first, cnt;
    logic [5:0] seen;
    set_cfg(1, 0, 0);
    t0 = cycle;
    tp = -1;
    set_en(6'b000010);
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (bus.remaining == 8'd9) begin tp = cycle; break; end
    end
    checks++; if (tp != t0 + 30) begin errors++; $display("FAIL pause_reach9: got %0d expected %0d", tp, t0 + 30); end
    bus.pause = 1'b1;
    set_en('0);
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 20) begin bus.pause = 1'b0; set_en(6'b000010); end
      if (bus.remaining !== 8'd9 || bus.phase_active !== 1'b1 || done_vec() != 6'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end
    // 20 paused cycles plus the resume cycle spent leaving HOLD
    watch(60, first, cnt, seen);
    checks++; if (first != t0 + 2 + 16 * TD + 21) begin errors++; $display("FAIL pause_time: got %0d expected %0d", first, t0 + 2 + 16 * TD + 21); end
    checks++; if (cnt != 1 || seen !== 6'b000010) begin errors++; $display("FAIL pause_pulse: got cnt=%0d seen=%b expected cnt=1 seen=000010", cnt, seen); end
    set_en('0);
    cyc(); cyc();
  endtask

  task automatic test_random();
    int p, d, t0, first, cnt;
    logic [5:0] seen;
    for (int it = 0; it < 10; it++) begin
      p = int'($urandom_range(0, 5));
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      d = ref_dur(p, int'(bus.cycle_duration), int'(bus.cloth_type), int'(bus.temp_select));
      t0 = cycle;
      set_en(6'b000001 << p);
      cyc(); cyc();
      checks++; if (bus.remaining !== 8'(d)) begin errors++; $display("FAIL rand_load[%0d]: got %0d expected %0d", it, bus.remaining, d); end
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      watch(d * TD + 4, first, cnt, seen);
      checks++; if (first != t0 + 2 + d * TD) begin errors++; $display("FAIL rand_time[%0d]: got %0d expected %0d", it, first, t0 + 2 + d * TD); end
      checks++; if (cnt != 1 || seen !== (6'b000001 << p)) begin errors++; $display("FAIL rand_pulse[%0d]: got cnt=%0d seen=%b expected cnt=1 phase %0d", it, cnt, seen, p); end
      set_en('0);
      cyc(); cyc();
    end
  endtask

  task automatic test_full_cycle();
    logic [5:0] got[$];
    int wide, tmo;
    wide = 0;
    tmo = 0;
    set_cfg(0, 0, 0);
    for (int p = 0; p < 6; p++) begin
      set_en(6'b000001 << p);
      for (int i = 0; i < 200 && done_vec() == 6'd0; i++) cyc();
      if (done_vec() == 6'd0) tmo++;
      else begin
        got.push_back(done_vec());
        cyc();
        if (done_vec() != 6'd0) wide++;
      end
      set_en('0);
      cyc();
      if (done_vec() != 6'd0) wide++;
      cyc();
      if (done_vec() != 6'd0) wide++;
    end
    checks++; if (tmo != 0) begin errors++; $display("FAIL full_timeout: got %0d timeouts expected 0", tmo); end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL full_count: got %0d pulses expected 6", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== (6'b000001 << i)) begin errors++; $display("FAIL full_order[%0d]: got %b expected %b", i, got[i], 6'b000001 << i); end
    end
    checks++; if (wide != 0) begin errors++; $display("FAIL full_width: got %0d extra done cycles expected 0", wide); end
  endtask

  task automatic test_multi_abort();
    int first, cnt;
    logic [5:0] seen;
    set_cfg(0, 0, 0);
    set_en(6'b001100);
    #1;
    checks++; if (bus.enable_error !== 1'b1) begin errors++; $display("FAIL multi_error: got %b expected 1", bus.enable_error); end
    cyc(); cyc();
    checks++; if (bus.phase_active !== 1'b0 || bus.enable_error !== 1'b1) begin errors++; $display("FAIL multi_idle: got active=%b error=%b expected active=0 error=1", bus.phase_active, bus.enable_error); end
    set_en('0);
    cyc();
    set_en(6'b000100);
    repeat (8) cyc();
    checks++; if (bus.phase_active !== 1'b1 || bus.remaining !== 8'd5) begin errors++; $display("FAIL abort_running: got active=%b remaining=%0d expected active=1 remaining=5", bus.phase_active, bus.remaining); end
    set_en('0);
    watch(40, first, cnt, seen);
    checks++; if (cnt != 0) begin errors++; $display("FAIL abort_nodone: got %0d done cycles expected 0", cnt); end
    checks++; if (bus.remaining !== 8'd0 || bus.phase_active !== 1'b0) begin errors++; $display("FAIL abort_clear: got remaining=%0d active=%b expected 0 0", bus.remaining, bus.phase_active); end
  endtask

  task automatic test_reset_mid();
    int t0, first, cnt;
    logic [5:0] seen;
    set_cfg(0, 0, 0);
    set_en(6'b100000);
    for (int i = 0; i < 100 && bus.remaining != 8'd5; i++) cyc();
    checks++; if (bus.remaining !== 8'd5) begin errors++; $display("FAIL rstmid_reach5: got %0d expected 5", bus.remaining); end
    reset = 1'b1;
    cyc();
    checks++; if (done_vec() !== 6'd0 || bus.remaining !== 8'd0 || bus.phase_active !== 1'b0 || bus.enable_error !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got done=%b remaining=%0d active=%b error=%b expected all 0", done_vec(), bus.remaining, bus.phase_active, bus.enable_error); end
    reset = 1'b0;
    t0 = cycle;
    cyc(); cyc();
    checks++; if (bus.remaining !== 8'd10) begin errors++; $display("FAIL rstmid_reload: got %0d expected 10", bus.remaining); end
    watch(50, first, cnt, seen);
    checks++; if (first != t0 + 2 + 10 * TD || seen !== 6'b100000) begin errors++; $display("FAIL rstmid_done: got cycle=%0d seen=%b expected cycle=%0d seen=100000", first, seen, t0 + 2 + 10 * TD); end
    set_en('0);
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_hot_fill();
    test_delicate_spin();
    test_pause();
    test_random();
    test_full_cycle();
    test_multi_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wm_phase_timer.md
Name: wm_phase_timer

Overview:
- Upstream timing stage for the washing-machine controller FSM. Watches the controller's one-hot phase enables (fill_water, wash, rinse, spin, drain, dry) and times each phase.
- Phase duration comes from cycle_duration, cloth_type and temp_select. At expiry it pulses the matching *_done input of the controller.
- Honours pause/resume: the elapsed count is frozen and kept across the controller's PAUSE/CONTINUE detour.

Parameters:
- TICK_DIV, 1000: clk cycles per time tick. Must be ≥ 2.
- CNT_W, 8: width of the remaining-ticks counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fill_water, wash, rinse, spin, drain, dry  in  1 each  phase enables from the controller
- pause  in  1  pause request (same signal the controller sees)
- cycle_duration  in  2  00=short, 01=medium, 10=long, 11 treated as 00
- cloth_type  in  2  00=cotton, any other value=delicate
- temp_select  in  2  00=cold, 01=warm, 10=hot, 11 treated as cold
- fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done  out  1 each  single-cycle expiry pulses
- remaining  out  CNT_W  ticks left in the current or held phase
- phase_active  out  1  high in LOAD, RUN or HOLD
- enable_error  out  1  high in any cycle where more than one phase enable is high

Behaviour:
- Reset values: all *_done=0, remaining=0, phase_active=0, enable_error=0, FSM=IDLE, prescaler=0, stored phase=NONE.
- FSM states: IDLE, LOAD, RUN, HOLD, DONE, WAIT_DROP.
- Phase durations in ticks for cycle_duration 00 / 01 / 10:
  - fill: 4 / 4 / 4; plus 2 if temp_select=10.
  - wash: 10 / 16 / 22.
  - rinse: 6 / 8 / 10.
  - spin: 4 / 6 / 8; halved (>>1) if delicate.
  - drain: 3 / 3 / 3.
  - dry: 10 / 14 / 20; halved (>>1) if delicate.
  - The minimum duration is 2, so zero never occurs.
- IDLE:
  - Exactly one enable high and pause low → store the phase index → LOAD.
  - Multi-hot enables → stay in IDLE with enable_error=1.
- LOAD (1 cycle):
  - remaining ← duration of the stored phase; prescaler ← 0 → RUN.
  - Configuration inputs are sampled only here. Changes during a phase have no effect.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps. At each wrap, remaining decrements.
  - A wrap with remaining=1 → remaining becomes 0 → DONE.
  - Latency: enable first seen in IDLE at cycle N gives the done pulse at cycle N+2+D*TICK_DIV.
- DONE (1 cycle): the stored phase's *_done=1 → WAIT_DROP.
- WAIT_DROP:
  - Stays until the stored phase's enable is low → IDLE.
  - This prevents retriggering the same phase.
- Pause:
  - In LOAD or RUN, pause=1 has priority over everything → HOLD. Prescaler and remaining are frozen, and the load still completes if pause arrives in LOAD.
  - All enables dropping while in HOLD is expected (controller PAUSE/CONTINUE) and is not an abort.
  - HOLD → RUN when pause=0 and the stored phase's enable is high again; the prescaler resumes from its held value.
  - HOLD → LOAD when pause=0 and a different single enable is high (new phase, restart).
- Abort:
  - In RUN with pause=0, the stored enable going low with no other enable high → IDLE with no done pulse; remaining is cleared.
  - In RUN, a different single enable → LOAD for that phase.
- Simultaneous events: a tick wrap on the same cycle as pause → freeze first; the decrement does not occur.
- Reset mid-operation: next edge goes to IDLE with every output at its reset value; no done pulse.
- *_done outputs are decoded from registered state and phase only, so they are glitch-free with no combinational input path.

Decomposition:
- Shared package wm_pkg:
  - Phase index enum: NONE, FILL, WASH, RINSE, SPIN, DRAIN, DRY.
  - Duration constants table indexed by phase and cycle_duration.
  - HOT_FILL_EXTRA=2.
  - Timer state encoding.
- Sub-module wm_tick_prescaler:
  - Inputs: clk, reset, clear, hold.
  - Output: tick, a 1-cycle pulse at each wrap.

Test Plan (TICK_DIV=4):
- Hot fill: cycle_duration=00, temp_select=10; fill_water rises at cycle 10 → fill_done high only at cycle 36 (10+2+6*4); remaining reads 6 at cycle 12.
- Delicate spin: cycle_duration=10, cloth_type=01; spin rises at cycle 0 → spin_done at cycle 18 (8>>1=4 ticks).
- Pause: wash, cycle_duration=01; pause high for 20 cycles at remaining=9 with wash dropped, then wash reasserted → remaining holds 9 throughout and wash_done arrives exactly 20+ cycles later than an unpaused run.
- Full cycle: the timer paired with the controller runs the whole sequence at cycle_duration=00 → six done pulses in order fill, wash, rinse, spin, drain, dry; each is exactly 1 cycle and there are no duplicates.
- Multi-hot and abort: rinse and spin both high → enable_error=1 with the FSM in IDLE. Rinse running then dropped with pause=0 → no rinse_done and remaining=0.
- Reset mid-RUN at remaining=5 → next cycle all outputs are 0; re-enabling dry restarts at the full duration.
